mem_block_ctrl: RTL and testbench

- Memory-controller stage directly downstream of the direct-mapped data cache.
- Accepts one block-wide read or write request per transaction on the cache-side interface (mci_request_t / mci_response_t fields, flattened into ports).
- Serialises each block into WORD_BITS-wide beats on a simple valid/ack backing-memory port, then returns a one-cycle completion pulse with the assembled block.

---
 rtl/mem_block_ctrl_if.sv | 31 +++
 rtl/mem_block_ctrl.sv | 88 ++++++++
 tb/tb_mem_block_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_block_ctrl_if.sv
// mem_block_ctrl_if: cache-side request/response plus backing-memory beat port
// of the block memory controller.
interface mem_block_ctrl_if #(
    parameter int ADDR_BITS  = 32,
    parameter int WORD_BITS  = 32,
    parameter int BLOCK_BITS = 128
);
    logic                  req_valid;
    logic                  req_rw;
    logic [ADDR_BITS-1:0]  req_addr;
    logic [BLOCK_BITS-1:0] req_data;
    logic                  res_ready;
    logic [BLOCK_BITS-1:0] res_data;
    logic                  mem_valid;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [WORD_BITS-1:0]  mem_wdata;
    logic                  mem_ack;
    logic [WORD_BITS-1:0]  mem_rdata;
    logic                  proto_err;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, mem_ack, mem_rdata,
        output res_ready, res_data, mem_valid, mem_we, mem_addr, mem_wdata, proto_err
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data, mem_ack, mem_rdata,
        input  res_ready, res_data, mem_valid, mem_we, mem_addr, mem_wdata, proto_err
    );
endinterface

// File: rtl/mem_block_ctrl.sv
// mem_block_ctrl: serialises block read/write-back requests into word beats on a
// valid/ack backing-memory port and returns a one-cycle completion pulse.
module mem_block_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int WORD_BITS  = 32,
    parameter int BLOCK_BITS = 128
) (
    input logic             clk,
    input logic             rst,
    mem_block_ctrl_if.slave bus
);
    localparam int BEATS = BLOCK_BITS / WORD_BITS;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [ADDR_BITS-1:0] OFF_MASK  = ADDR_BITS'(BLOCK_BITS / 8 - 1);
    localparam logic [ADDR_BITS-1:0] WORD_STEP = ADDR_BITS'(WORD_BITS / 8);
    localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                          state;
    logic                            rw;
    logic [BW-1:0]                   beat;
    logic [BW-1:0]                   beat_nx;
    logic [BEATS-1:0][WORD_BITS-1:0] blk;
    logic [BEATS-1:0][WORD_BITS-1:0] blk_nx;
    logic [BEATS-1:0][WORD_BITS-1:0] req_words;

    assign req_words = bus.req_data;
    assign beat_nx   = beat + BW'(1);

    // Block with the current beat's read word merged in, so the last beat can go straight to res_data.
    always_comb begin
        blk_nx = blk;
        if (!rw) blk_nx[beat] = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            rw            <= 1'b0;
            beat          <= '0;
            blk           <= '0;
            bus.res_ready <= 1'b0;
            bus.res_data  <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.proto_err <= 1'b0;
        end else begin
            bus.res_ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // A new request is accepted in DONE too, so a refill can follow a write-back back to back.
                    if (bus.req_valid) begin
                        state         <= XFER;
                        rw            <= bus.req_rw;
                        beat          <= '0;
                        blk           <= req_words;
                        bus.mem_valid <= 1'b1;
                        bus.mem_we    <= bus.req_rw;
                        bus.mem_addr  <= bus.req_addr & ~OFF_MASK;
                        bus.mem_wdata <= req_words[0];
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (bus.req_valid) bus.proto_err <= 1'b1;
                    if (bus.mem_ack) begin
                        blk <= blk_nx;
                        if (beat == LAST_BEAT) begin
                            state         <= DONE;
                            bus.mem_valid <= 1'b0;
                            bus.res_ready <= 1'b1;
                            bus.res_data  <= blk_nx;
                        end else begin
                            beat          <= beat_nx;
                            bus.mem_addr  <= bus.mem_addr + WORD_STEP;
                            bus.mem_wdata <= blk_nx[beat_nx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_block_ctrl.sv
// tb_mem_block_ctrl: directed checks of mem_block_ctrl against a backing memory
// returning 0xA0+k for word k above 0x1000, with a programmable ack delay.
module tb_mem_block_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   wt_n = 0;
    int   wcnt = 0;
    int   pulses = 0;
    int   p0;
    logic stray = 1'b0;
    logic [127:0] keep;

    mem_block_ctrl_if #(.ADDR_BITS(32), .WORD_BITS(32), .BLOCK_BITS(128)) bus ();

    mem_block_ctrl #(.ADDR_BITS(32), .WORD_BITS(32), .BLOCK_BITS(128)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_ack   = stray || (bus.mem_valid && wcnt == wt_n);
    assign bus.mem_rdata = 32'hA0 + ((bus.mem_addr - 32'h1000) >> 2);

    always @(posedge clk) begin
        wcnt <= (bus.mem_valid && !bus.mem_ack) ? wcnt + 1 : 0;
        if (bus.res_ready) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [31:0] addr, input logic [127:0] data);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_data  = data;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Walks every beat (checking address, direction, write data, hold during waits) and ends in the DONE cycle.
    task automatic run_blk(input string tag, input logic rw, input logic [31:0] addr, input logic [31:0] base,
                           input logic [127:0] data, input int wt, input logic [127:0] exp);
        wt_n = wt;
        issue(rw, addr, data);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= wt; w++) begin
                chk({tag, "_beat"}, {bus.mem_valid, bus.mem_we, bus.mem_addr, rw ? bus.mem_wdata : 32'h0},
                    {1'b1, rw, base + 32'(4 * k), rw ? data[32*k +: 32] : 32'h0});
                chk({tag, "_nordy"}, 128'(bus.res_ready), 128'd0);
                tick();
            end
        end
        chk({tag, "_rdy"}, 128'(bus.res_ready), 128'd1);
        chk({tag, "_data"}, bus.res_data, exp);
        chk({tag, "_mvdrop"}, 128'(bus.mem_valid), 128'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        tick();
        tick();
        chk("rst_outs", {bus.res_ready, bus.mem_valid, bus.mem_we, bus.proto_err, bus.mem_addr, bus.mem_wdata}, 128'd0);
        chk("rst_data", bus.res_data, 128'd0);
        rst = 1'b1;
        tick();

        run_blk("rd", 1'b0, 32'h100C, 32'h1000, 128'd0, 0,
                128'h000000A3_000000A2_000000A1_000000A0);
        tick();
        chk("rd_idle", {bus.res_ready, bus.mem_valid}, 128'd0);

        run_blk("wr", 1'b1, 32'h2000, 32'h2000, 128'h44444444_33333333_22222222_11111111, 2,
                128'h44444444_33333333_22222222_11111111);
        tick();
        chk("wr_idle", {bus.res_ready, bus.mem_valid}, 128'd0);

        p0 = pulses;
        run_blk("wb", 1'b1, 32'h3000, 32'h3000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        run_blk("rf", 1'b0, 32'h4000, 32'h4000, 128'd0, 0,
                128'h00000CA3_00000CA2_00000CA1_00000CA0);
        tick();
        tick();
        chk("rf_pulses", 128'(pulses - p0), 128'd2);

        wt_n = 0;
        issue(1'b0, 32'h1004, 128'd0);
        tick();
        tick();
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 32'h5000;
        tick();
        bus.req_valid = 1'b0;
        chk("col_err", 128'(bus.proto_err), 128'd1);
        chk("col_addr", 128'(bus.mem_addr), 128'h100C);
        tick();
        chk("col_rdy", 128'(bus.res_ready), 128'd1);
        chk("col_data", bus.res_data, 128'h000000A3_000000A2_000000A1_000000A0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("col_quiet", {bus.mem_valid, bus.res_ready, bus.proto_err}, 128'b001);
        end

        issue(1'b0, 32'h1000, 128'd0);
        tick();
        chk("mid_beat1", 128'(bus.mem_addr), 128'h1004);
        rst = 1'b0;
        p0  = pulses;
        tick();
        chk("mid_outs", {bus.res_ready, bus.mem_valid, bus.mem_we, bus.proto_err, bus.mem_addr, bus.mem_wdata}, 128'd0);
        chk("mid_data", bus.res_data, 128'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_nopulse", 128'(pulses - p0), 128'd0);
        run_blk("post", 1'b0, 32'h1008, 32'h1000, 128'd0, 0,
                128'h000000A3_000000A2_000000A1_000000A0);
        tick();

        keep  = bus.res_data;
        p0    = pulses;
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_quiet", {bus.res_ready, bus.mem_valid}, 128'd0);
        end
        stray = 1'b0;
        tick();
        chk("stray_data", bus.res_data, keep);
        chk("stray_nopulse", 128'(pulses - p0), 128'd0);
        run_blk("after", 1'b0, 32'h1000, 32'h1000, 128'd0, 1,
                128'h000000A3_000000A2_000000A1_000000A0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
